// File: rtl/mips_data_memory_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
// The memory reports ready and returns load results or alignment faults one cycle after acceptance.
interface mips_data_memory_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req;
    logic                  we;
    logic [1:0]            size;
    logic                  sign_ext;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  ready;
    logic [31:0]           rdata;
    logic                  rvalid;
    logic                  misaligned;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  ready, rdata, rvalid, misaligned
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output ready, rdata, rvalid, misaligned
    );
endinterface

// File: rtl/mips_data_memory.sv
// Byte-addressable MIPS data memory: byte/half/word accesses, load extension,
// alignment faults, registered read result and an optional clear-after-reset sweep.
module mips_data_memory #(
    parameter int ADDR_WIDTH     = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mips_data_memory_if.slave bus
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int WORDS = 2 ** IDX_W;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] clr_cnt;
    logic [IDX_W-1:0] clr_cnt_next;

    logic [31:0] mem [WORDS];

    logic [IDX_W-1:0] idx_p0;
    logic [1:0]       off_p0;
    logic             accept_p0;
    logic             legal_p0;
    logic             load_p0;
    logic             bad_p0;
    logic [3:0]       be_p0;
    logic [31:0]      lanes_p0;
    logic             init_wr_p0;

    logic [31:0] rdata_p1;
    logic        rvalid_p1;
    logic        misaligned_p1;

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the right-justified store data so every candidate lane carries it.
    function automatic logic [31:0] align_store(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        sext
    );
        logic [31:0]        shifted;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [31:0]        result;
        shifted = word >> {off, 3'b000};
        byte_s  = signed'(shifted[7:0]);
        half_s  = signed'(shifted[15:0]);
        case (size)
            2'b00:   result = sext ? 32'(byte_s) : {24'h0, shifted[7:0]};
            2'b01:   result = sext ? 32'(half_s) : {16'h0, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

    // ---- p0: request decode at the accepting edge ----
    assign idx_p0     = bus.addr[ADDR_WIDTH-1:2];
    assign off_p0     = bus.addr[1:0];
    assign accept_p0  = bus.req && (state == ST_READY) && !rst;
    assign legal_p0   = is_legal(bus.size, off_p0);
    assign load_p0    = accept_p0 && legal_p0 && !bus.we;
    assign bad_p0     = accept_p0 && !legal_p0;
    assign be_p0      = (accept_p0 && legal_p0 && bus.we) ? lane_enables(bus.size, off_p0) : 4'b0000;
    assign lanes_p0   = align_store(bus.size, bus.wdata);
    assign init_wr_p0 = (state == ST_INIT) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        if (state == ST_INIT) begin
            clr_cnt_next = clr_cnt + 1'b1;
            if (clr_cnt == IDX_W'(WORDS - 1)) begin
                state_next = ST_READY;
            end
        end
    end

    // The clear sweep and pipeline stores never coincide: stores need ST_READY.
    always_ff @(posedge clk) begin
        if (init_wr_p0) begin
            mem[clr_cnt] <= 32'h0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (be_p0[k]) begin
                    mem[idx_p0][8*k +: 8] <= lanes_p0[8*k +: 8];
                end
            end
        end
    end

    // ---- p1: registered load result and status pulses ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1      <= 32'h0;
            rvalid_p1     <= 1'b0;
            misaligned_p1 <= 1'b0;
        end else begin
            rvalid_p1     <= load_p0;
            misaligned_p1 <= bad_p0;
            if (load_p0) begin
                rdata_p1 <= extend_load(mem[idx_p0], bus.size, off_p0, bus.sign_ext);
            end
        end
    end

    assign bus.ready      = (state == ST_READY);
    assign bus.rdata      = rdata_p1;
    assign bus.rvalid     = rvalid_p1;
    assign bus.misaligned = misaligned_p1;
endmodule

// File: tb/tb_mips_data_memory.sv
// Scoreboard bench for mips_data_memory (ADDR_WIDTH=6, clear-on-reset): directed cases,
// randomized traffic against a byte-array reference model, and reset-during-clear behaviour.
module tb_mips_data_memory;
    localparam int AW    = 6;
    localparam int WORDS = 16;
    localparam int BYTES = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_data_memory_if #(.ADDR_WIDTH(AW)) bus ();

    mips_data_memory #(
        .ADDR_WIDTH    (AW),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [31:0]  exp_hold = 32'h0;
    byte unsigned model[BYTES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int nbytes_of(input int sz);
        return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endfunction

    function automatic bit legal(input int sz, input int a);
        case (sz)
            0:       return 1'b1;
            1:       return (a % 2) == 0;
            2:       return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input int sz, input int a, input bit sx);
        logic [31:0] v;
        logic [31:0] mask;
        int          n;
        n = nbytes_of(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(model[a + i]) << (8 * i));
        if (sx && n < 4 && v[8*n-1]) begin
            mask = 32'hFFFF_FFFF << (8 * n);
            v    = v | mask;
        end
        return v;
    endfunction

    // Drive one request for the next rising edge; record what the model says it should do.
    task automatic issue(input bit w, input int sz, input bit sx, input int a, input logic [31:0] d);
        @(negedge clk);
        bus.req      = 1'b1;
        bus.we       = w;
        bus.size     = 2'(sz);
        bus.sign_ext = sx;
        bus.addr     = 6'(a);
        bus.wdata    = d;
        if (bus.ready === 1'b1) begin
            if (!legal(sz, a)) begin
                sb.push_back('{is_load: 1'b0, data: 32'h0, due: cyc + 1});
            end else if (w) begin
                for (int i = 0; i < nbytes_of(sz); i++) model[a + i] = 8'(d >> (8 * i));
            end else begin
                sb.push_back('{is_load: 1'b1, data: model_load(sz, a, sx), due: cyc + 1});
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
    endtask

    // Counts clear-sweep cycles; optionally fires a store then a load into the sweep.
    task automatic wait_init(input int inj, output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            bus.req   = (inj >= 0) && (n == inj || n == inj + 1);
            bus.we    = (n == inj);
            bus.size  = 2'b10;
            bus.addr  = (n == inj) ? 6'h00 : 6'h04;
            bus.wdata = 32'hA5A5_A5A5;
            @(negedge clk);
            n++;
        end
        bus.req = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < BYTES; i++) model[i] = 8'h00;
    endtask

    // Monitor: pops the scoreboard when a pulse is due, otherwise demands quiet outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                exp_hold = 32'h0;
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("rvalid_pulse", 32'(bus.rvalid), 32'(e.is_load));
                check("misaligned_pulse", 32'(bus.misaligned), 32'(!e.is_load));
                if (e.is_load) begin
                    check("load_rdata", bus.rdata, e.data);
                    exp_hold = e.data;
                end else begin
                    check("fault_rdata_hold", bus.rdata, exp_hold);
                end
            end else begin
                check("quiet_rvalid", 32'(bus.rvalid), 32'h0);
                check("quiet_misaligned", 32'(bus.misaligned), 32'h0);
                check("quiet_rdata_hold", bus.rdata, exp_hold);
            end
        end
    end

    initial begin
        int n;
        bus.req      = 1'b0;
        bus.we       = 1'b0;
        bus.size     = 2'b00;
        bus.sign_ext = 1'b0;
        bus.addr     = '0;
        bus.wdata    = 32'h0;
        rst          = 1'b1;

        @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.ready), 32'h0);
        check("reset_rvalid", 32'(bus.rvalid), 32'h0);
        check("reset_misaligned", 32'(bus.misaligned), 32'h0);
        check("reset_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_init(-1, n);
        check("init_cycles", 32'(n), 32'(WORDS));
        clear_model();

        issue(0, 2, 0, 'h3C, 32'h0);
        issue(1, 2, 0, 'h10, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) issue(0, 0, 1, 'h10 + k, 32'h0);
        issue(0, 0, 0, 'h13, 32'h0);
        issue(1, 1, 0, 'h12, 32'h0000_1234);
        issue(0, 2, 0, 'h10, 32'h0);
        issue(0, 1, 1, 'h10, 32'h0);
        issue(0, 2, 0, 'h11, 32'h0);
        issue(1, 1, 0, 'h13, 32'h0000_FFFF);
        issue(0, 3, 0, 'h00, 32'h0);
        issue(0, 2, 0, 'h10, 32'h0);
        idle(1);
        issue(1, 2, 0, 'h00, 32'h1111_1111);
        issue(1, 2, 0, 'h04, 32'h2222_2222);
        issue(1, 2, 0, 'h08, 32'h3333_3333);
        issue(0, 2, 0, 'h00, 32'h0);
        issue(0, 2, 0, 'h04, 32'h0);
        issue(0, 2, 0, 'h08, 32'h0);
        idle(2);

        repeat (400) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, BYTES - 1), $urandom);
        end
        idle(3);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_init_ready", 32'(bus.ready), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_init(13, n);
        check("restart_init_cycles", 32'(n), 32'(WORDS));
        clear_model();
        issue(0, 2, 0, 'h00, 32'h0);
        issue(0, 2, 0, 'h04, 32'h0);
        issue(0, 2, 0, 'h34, 32'h0);
        idle(3);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
